// File: rtl/up_bus_responder_pkg.sv
// Shared types and constants for the microcontroller bus responder.
// Packet sizes, command codes, FSM encoding and the read-packet byte mux.
package up_bus_responder_pkg;

  typedef logic [7:0] byte_t;

  localparam int NOS_WRITE_BYTES = 6;
  localparam int NOS_READ_BYTES  = 8;

  localparam byte_t READ_REGISTER_CMD  = 8'h00;
  localparam byte_t WRITE_REGISTER_CMD = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    WR_H1_HI,
    WR_H1_LO,
    EXEC,
    RD_SETUP,
    RD_H1_HI,
    RD_H1_LO,
    ACK
  } resp_state_t;

  // Read packet order: data bytes 0..3 then status bytes 4..7, LSB first.
  function automatic byte_t resp_byte(input logic [31:0] data,
                                      input logic [31:0] status,
                                      input logic [2:0]  idx);
    logic [63:0] word;
    word = {status, data};
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/up_bus_responder_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Latency SYNC_STAGES clocks; no backpressure.
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= (chain << 1) | SYNC_STAGES'(d);
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/up_bus_responder.sv
// FPGA-side responder for the async 8-bit uP bus: 6-byte write packet in, 8-byte read packet out.
// Each byte is paced by the uP through handshake_1/handshake_2; the register bank stalls via resp_valid.
module up_bus_responder
  import up_bus_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned ACK_MIN_CYCLES = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        async_uP_start,
  input  logic        async_uP_handshake_1,
  input  logic        async_uP_RW,
  input  logic [7:0]  uP_data_in,
  output logic [7:0]  uP_data_out,
  output logic        uP_data_oe,
  output logic        uP_handshake_2,
  output logic        uP_ack,
  output logic        cmd_valid,
  output logic [7:0]  command,
  output logic [7:0]  reg_address,
  output logic [31:0] reg_data,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic [31:0] resp_status,
  output logic        timeout_err
);

  localparam int unsigned TO_MAX = (TIMEOUT_CYCLES > ACK_MIN_CYCLES) ? TIMEOUT_CYCLES : ACK_MIN_CYCLES;
  localparam int unsigned TW     = $clog2(TO_MAX + 1);
  localparam int unsigned SW     = $clog2(SETUP_CYCLES + 1);

  logic start_s, h1_s, rw_s;
  logic start_s_q;
  logic start_rise;

  resp_state_t state, state_n;
  logic [2:0]  count, count_n;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] setup_cnt;

  byte_t       packet [NOS_WRITE_BYTES];
  logic [31:0] resp_data_q;
  logic [31:0] resp_status_q;

  logic latch_byte, load_cmd, latch_resp, abort, start_txn, timed_state;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clk   (clk),
    .reset (reset),
    .d     (async_uP_start),
    .q     (start_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_h1 (
    .clk   (clk),
    .reset (reset),
    .d     (async_uP_handshake_1),
    .q     (h1_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rw (
    .clk   (clk),
    .reset (reset),
    .d     (async_uP_RW),
    .q     (rw_s)
  );

  assign start_rise  = start_s & ~start_s_q;
  assign timed_state = (state != IDLE) && (state != EXEC);

  always_comb begin
    state_n    = state;
    count_n    = count;
    latch_byte = 1'b0;
    load_cmd   = 1'b0;
    latch_resp = 1'b0;
    abort      = 1'b0;
    start_txn  = 1'b0;

    case (state)
      IDLE: begin
        if (start_rise) begin
          start_txn = 1'b1;
          count_n   = '0;
          state_n   = WR_H1_HI;
        end
      end
      WR_H1_HI: begin
        if (h1_s) begin
          latch_byte = 1'b1;
          state_n    = WR_H1_LO;
        end
      end
      WR_H1_LO: begin
        if (!h1_s) begin
          if (count == 3'(NOS_WRITE_BYTES - 1)) begin
            load_cmd = 1'b1;
            state_n  = EXEC;
          end else begin
            count_n = count + 3'd1;
            state_n = WR_H1_HI;
          end
        end
      end
      EXEC: begin
        if (resp_valid) begin
          latch_resp = 1'b1;
          count_n    = '0;
          state_n    = RD_SETUP;
        end
      end
      RD_SETUP: begin
        if (!rw_s && (setup_cnt == SW'(SETUP_CYCLES - 1))) begin
          state_n = RD_H1_HI;
        end
      end
      RD_H1_HI: begin
        if (h1_s) begin
          state_n = RD_H1_LO;
        end
      end
      RD_H1_LO: begin
        if (!h1_s) begin
          if (count == 3'(NOS_READ_BYTES - 1)) begin
            state_n = ACK;
          end else begin
            count_n = count + 3'd1;
            state_n = RD_SETUP;
          end
        end
      end
      ACK: begin
        if ((to_cnt >= TW'(ACK_MIN_CYCLES - 1)) && !start_s) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // A stalled uP abandons the transaction; whatever packet was partially received is dropped.
    if (timed_state && (state_n == state) && (to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
      state_n = IDLE;
      abort   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      to_cnt         <= '0;
      setup_cnt      <= '0;
      start_s_q      <= 1'b0;
      resp_data_q    <= '0;
      resp_status_q  <= '0;
      command        <= '0;
      reg_address    <= '0;
      reg_data       <= '0;
      cmd_valid      <= 1'b0;
      timeout_err    <= 1'b0;
      uP_handshake_2 <= 1'b0;
      uP_ack         <= 1'b0;
      for (int i = 0; i < NOS_WRITE_BYTES; i++) begin
        packet[i] <= '0;
      end
    end else begin
      state     <= state_n;
      count     <= count_n;
      start_s_q <= start_s;

      if (state_n != state) begin
        to_cnt <= '0;
      end else if (to_cnt != {TW{1'b1}}) begin
        to_cnt <= to_cnt + 1'b1;
      end

      // Only consecutive driven cycles count toward data setup before the strobe.
      if ((state != RD_SETUP) || rw_s || (state_n != state)) begin
        setup_cnt <= '0;
      end else begin
        setup_cnt <= setup_cnt + 1'b1;
      end

      if (latch_byte) begin
        packet[count] <= uP_data_in;
      end

      cmd_valid <= load_cmd;
      if (load_cmd) begin
        command     <= packet[0];
        reg_address <= packet[1];
        reg_data    <= {packet[5], packet[4], packet[3], packet[2]};
      end

      if (latch_resp) begin
        resp_data_q   <= resp_data;
        resp_status_q <= resp_status;
      end

      if (abort) begin
        timeout_err <= 1'b1;
      end else if (start_txn) begin
        timeout_err <= 1'b0;
      end

      // Strobes to the uP come straight from flops so the async receiver never sees decode glitches.
      uP_handshake_2 <= (state_n == WR_H1_LO) || (state_n == RD_H1_HI);
      uP_ack         <= (state_n == ACK);
    end
  end

  assign uP_data_oe  = ((state == RD_SETUP) && !rw_s) || (state == RD_H1_HI);
  assign uP_data_out = uP_data_oe ? resp_byte(resp_data_q, resp_status_q, count) : 8'h00;

endmodule

// File: doc/up_bus_responder.md
Name: up_bus_responder

Overview:
- FPGA-side responder for the asynchronous 8-bit microcontroller bus of motion_system.
- Receives a 6-byte write packet: command, register address, then 4 data bytes LSB first.
- Presents the packet to the register bank and waits for its response.
- Returns an 8-byte read packet (4 data bytes then 4 status bytes, LSB first) using the handshake_1/handshake_2 protocol, then signals uP_ack.
- Sits between the top-level pins (tristate at top) and the register/command decoder.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each async input (start, handshake_1, RW).
- SETUP_CYCLES, 2, clocks data_out is driven before handshake_2 rises in read phase.
- ACK_MIN_CYCLES, 8, minimum clocks uP_ack is held high.
- TIMEOUT_CYCLES, 50000, clocks without progress in any wait state before abort.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- async_uP_start  in  1  transaction start from uP (async).
- async_uP_handshake_1  in  1  uP strobe/ack (async).
- async_uP_RW  in  1  1 = uP driving bus, 0 = FPGA may drive (async).
- uP_data_in  in  8  bus value from pad.
- uP_data_out  out  8  value to drive on bus.
- uP_data_oe  out  1  pad output enable.
- uP_handshake_2  out  1  FPGA strobe/ack.
- uP_ack  out  1  transaction complete.
- cmd_valid  out  1  one-cycle pulse: packet received.
- command  out  8  packet byte 0.
- reg_address  out  8  packet byte 1.
- reg_data  out  32  packet bytes 2..5, byte 2 = bits 7:0.
- resp_valid  in  1  register bank response ready (may equal cmd_valid+N, N>=0 cycles later).
- resp_data  in  32  returned register data.
- resp_status  in  32  returned status word.
- timeout_err  out  1  sticky; set on abort, cleared by next start rising edge.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Byte counter 0.
  - Packet and response registers 0.
- All async inputs pass through SYNC_STAGES synchronizers; edge detection is done on synchronized values only.
- IDLE: a rising edge of start_s moves to WR_H1_HI, clears the byte counter and timeout_err. Start level is ignored after this (the uP may drop start early).
- WR_H1_HI: when h1_s=1, latch uP_data_in into packet[count] (the bus is stable because the protocol puts data before h1), set handshake_2=1, go to WR_H1_LO.
- WR_H1_LO: when h1_s=0, set handshake_2=0.
  - If count=5, go to EXEC; else count++ and go to WR_H1_HI.
- EXEC: pulse cmd_valid for exactly one cycle on entry. Wait for resp_valid, latch resp_data/resp_status, count=0, go to RD_SETUP.
  - resp_valid in the same cycle as cmd_valid is accepted.
- RD_SETUP: uP_data_out = response byte[count], where bytes 0..3 = resp_data LSB first and 4..7 = resp_status LSB first.
  - uP_data_oe = 1 only while RW_s=0; otherwise hold oe low and wait (no bus contention).
  - After SETUP_CYCLES consecutive cycles with oe=1, set handshake_2=1 and go to RD_H1_HI.
- RD_H1_HI: when h1_s=1, set handshake_2=0, drop oe, go to RD_H1_LO.
- RD_H1_LO: when h1_s=0:
  - If count=7, go to ACK.
  - Else count++ and go to RD_SETUP.
- ACK: uP_ack=1. Return to IDLE after ACK_MIN_CYCLES have elapsed and start_s=0; uP_ack=0 in IDLE.
- Timeout:
  - A counter resets on every state change.
  - If any wait state except EXEC and IDLE reaches TIMEOUT_CYCLES, go to IDLE with timeout_err=1, handshake_2=0, oe=0, and no cmd_valid.
  - A partial packet is discarded.
- A start rising edge while not in IDLE is ignored.
- Reset mid-transaction returns to IDLE the next clock with all outputs 0.
- command, reg_address and reg_data hold their values until the next packet completes.

Decomposition:
- Shared package (types):
  - byte_t.
  - Constants NOS_WRITE_BYTES=6 and NOS_READ_BYTES=8.
  - READ_REGISTER_CMD=0, WRITE_REGISTER_CMD=1.
  - Responder state enum.
- Sub-module: sync_bit (parameterized SYNC_STAGES flop chain), instantiated three times.

Test Plan:
- Write 01,05,78,56,34,12 via standard handshakes, with resp_valid 3 cycles after cmd_valid, resp_data=CAFEBABE, resp_status=00000001:
  - One cmd_valid pulse with command=01, reg_address=05, reg_data=12345678.
  - Read bytes BE,BA,FE,CA,01,00,00,00.
  - uP_ack high for at least 8 cycles.
- Start pulsed for only 100 ns then held low through the packet → transaction completes normally; ack still held ACK_MIN_CYCLES.
- RW held 1 for 500 ns after the write phase ends → uP_data_oe stays 0 and handshake_2 stays 0 until RW=0, then SETUP_CYCLES later handshake_2 rises.
- Stop the uP after byte 3 of the write packet, with TIMEOUT_CYCLES=100 → after 100 cycles state is IDLE, timeout_err=1, no cmd_valid. The next full transaction succeeds and timeout_err clears.
- Assert reset during read byte 4 → next cycle handshake_2=0, oe=0, uP_ack=0, and a new transaction returns the correct 8 bytes.
- Two back-to-back transactions (write then READ_REGISTER_CMD addr 05, resp_data=00000064) → the second read packet returns 64,00,00,00, and exactly two cmd_valid pulses are seen in total.
